// File: rtl/tile_dma_pkg.sv
// Shared types for the tile DMA arbiter: FSM states and transfer direction.
package tile_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    DIR_LOAD  = 1'b0,
    DIR_STORE = 1'b1
  } dir_t;

  localparam int unsigned N_REQ_MIN = 2;
  localparam int unsigned N_REQ_MAX = 8;

endpackage : tile_dma_pkg

// File: rtl/tile_dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of mask_i at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         mask_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 valid_c_o,
  output logic [N-1:0]         onehot_c_o,
  output logic [$clog2(N)-1:0] idx_c_o
);

  localparam int unsigned IDX_W = $clog2(N);

  int unsigned pos;

  always_comb begin
    valid_c_o  = 1'b0;
    onehot_c_o = '0;
    idx_c_o    = '0;
    pos        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr_i) + k) % N;
      if (!valid_c_o && mask_i[pos]) begin
        valid_c_o       = 1'b1;
        onehot_c_o[pos] = 1'b1;
        idx_c_o         = IDX_W'(pos);
      end
    end
  end

endmodule : rr_pick

// File: rtl/tile_dma_arbiter.sv
// Shares one tile DMA engine between N_REQ requesters: store-priority round-robin,
// one transfer outstanding, start/done handshake and an optional completion watchdog.
module tile_dma_arbiter
  import tile_dma_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned X_W        = 6,
  parameter int unsigned Y_W        = 6,
  parameter int unsigned STORE_PRIO = 1,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         req_dir_i,
  input  logic [N_REQ*X_W-1:0]     req_x_i,
  input  logic [N_REQ*Y_W-1:0]     req_y_i,
  input  logic [N_REQ-1:0]         req_buf_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         done_o,
  output logic                     dma_start_o,
  output logic                     dma_dir_o,
  output logic [X_W-1:0]           dma_x_o,
  output logic [Y_W-1:0]           dma_y_o,
  output logic                     dma_buf_o,
  input  logic                     dma_done_i,
  output logic                     busy_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     err_timeout_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  dir_t               dir_q, dir_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               buf_q, buf_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               err_q, err_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   store_mask;
  logic [N_REQ-1:0]   pick_mask;
  logic               pick_valid;
  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   owner_onehot;
  int unsigned        sel_x;
  int unsigned        sel_y;

  // Stores only compete among themselves whenever any store is pending.
  always_comb begin
    store_mask = req_i & req_dir_i;
    pick_mask  = req_i;
    if (STORE_PRIO != 0 && |store_mask) begin
      pick_mask = store_mask;
    end
  end

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .mask_i     (pick_mask),
    .ptr_i      (rr_ptr_q),
    .valid_c_o  (pick_valid),
    .onehot_c_o (pick_onehot),
    .idx_c_o    (pick_idx)
  );

  assign owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign sel_x        = 32'(pick_idx) * X_W;
  assign sel_y        = 32'(pick_idx) * Y_W;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    buf_d    = buf_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    gnt_d    = '0;
    done_d   = '0;
    start_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          dir_d   = dir_t'(req_dir_i[pick_idx]);
          x_d     = req_x_i[sel_x +: X_W];
          y_d     = req_y_i[sel_y +: Y_W];
          buf_d   = req_buf_i[pick_idx];
          wdog_d  = '0;
          gnt_d   = pick_onehot;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dma_done_i) begin
          done_d  = owner_onehot;
          state_d = S_RELEASE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dma_done_i) begin
          done_d  = owner_onehot;
          state_d = S_RELEASE;
        end else if (TIMEOUT != 0) begin
          // wdog_q holds completed WAIT cycles; this one is the TIMEOUT-th.
          if (32'(wdog_q) + 1 >= TIMEOUT) begin
            err_d   = 1'b1;
            done_d  = owner_onehot;
            state_d = S_RELEASE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end
      S_RELEASE: begin
        rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      dir_q    <= DIR_LOAD;
      x_q      <= '0;
      y_q      <= '0;
      buf_q    <= 1'b0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      buf_q    <= buf_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign done_o        = done_q;
  assign dma_start_o   = start_q;
  assign dma_dir_o     = dir_q;
  assign dma_x_o       = x_q;
  assign dma_y_o       = y_q;
  assign dma_buf_o     = buf_q;
  assign busy_o        = busy_q;
  assign owner_o       = owner_q;
  assign err_timeout_o = err_q;

endmodule : tile_dma_arbiter

// File: tb/tb_tile_dma_arbiter.sv
// Scoreboard bench for tile_dma_arbiter: store-priority instance with watchdog,
// plus a plain round-robin instance sharing the same stimulus.
module tb_tile_dma_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req_dir, req_buf;
  logic [23:0] req_x, req_y;
  logic        dma_done;

  logic [3:0]  gnt, done;
  logic        dma_start, dma_dir, dma_buf, busy, err_timeout;
  logic [5:0]  dma_x, dma_y;
  logic [1:0]  owner;

  logic [3:0]  rr_gnt, rr_done;
  logic        rr_start, rr_dir, rr_buf, rr_busy, rr_err;
  logic [5:0]  rr_x, rr_y;
  logic [1:0]  rr_owner;

  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          start_base;
  logic [3:0]  exp_gnt_q[$];
  logic [3:0]  exp_done_q[$];

  tile_dma_arbiter #(
    .N_REQ(4), .X_W(6), .Y_W(6), .STORE_PRIO(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_dir_i(req_dir), .req_x_i(req_x),
    .req_y_i(req_y), .req_buf_i(req_buf), .gnt_o(gnt), .done_o(done),
    .dma_start_o(dma_start), .dma_dir_o(dma_dir), .dma_x_o(dma_x), .dma_y_o(dma_y),
    .dma_buf_o(dma_buf), .dma_done_i(dma_done), .busy_o(busy), .owner_o(owner),
    .err_timeout_o(err_timeout)
  );

  tile_dma_arbiter #(
    .N_REQ(4), .X_W(6), .Y_W(6), .STORE_PRIO(0), .TIMEOUT(0)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_dir_i(req_dir), .req_x_i(req_x),
    .req_y_i(req_y), .req_buf_i(req_buf), .gnt_o(rr_gnt), .done_o(rr_done),
    .dma_start_o(rr_start), .dma_dir_o(rr_dir), .dma_x_o(rr_x), .dma_y_o(rr_y),
    .dma_buf_o(rr_buf), .dma_done_i(dma_done), .busy_o(rr_busy), .owner_o(rr_owner),
    .err_timeout_o(rr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic d, input int x, input int y, input logic b);
    req_dir[i]        = d;
    req_x[i*6 +: 6]   = 6'(x);
    req_y[i*6 +: 6]   = 6'(y);
    req_buf[i]        = b;
  endtask

  // Called at the ISSUE cycle: n more cycles, dma_done pulse, then RELEASE and back to IDLE.
  task automatic finish_dma(input int n);
    repeat (n) step();
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    step();
  endtask

  // Scoreboard: every grant/done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dma_start) start_cnt++;
      if (gnt != 4'b0 || dma_start)
        check_eq("start_with_gnt", 32'(dma_start), 32'(|gnt));
      if (gnt != 4'b0) begin
        if (exp_gnt_q.size() == 0) check_eq("gnt_unexpected", 32'(gnt), 32'(0));
        else                       check_eq("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
      end
      if (done != 4'b0) begin
        if (exp_done_q.size() == 0) check_eq("done_unexpected", 32'(done), 32'(0));
        else                        check_eq("done", 32'(done), 32'(exp_done_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; req = '0; req_dir = '0; req_buf = '0;
    req_x = '0; req_y = '0; dma_done = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_start", 32'(dma_start), 0);
    check_eq("rst_owner", 32'(owner), 0);
    check_eq("rst_err", 32'(err_timeout), 0);
    rst_n = 1'b1;
    step();

    // Store beats load; plain RR instance takes requester 0 first.
    set_cmd(0, 1'b0, 1, 1, 1'b0);
    set_cmd(2, 1'b1, 5, 4, 1'b1);
    req = 4'b0101;
    exp_gnt_q.push_back(4'b0100); exp_gnt_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0100); exp_done_q.push_back(4'b0001);
    step();
    check_eq("t2_owner", 32'(owner), 2);
    check_eq("t2_dir", 32'(dma_dir), 1);
    check_eq("t2_rr_gnt", 32'(rr_gnt), 32'(4'b0001));
    req[2] = 1'b0;
    finish_dma(2);
    step();
    check_eq("t2_second_owner", 32'(owner), 0);
    check_eq("t2_second_dir", 32'(dma_dir), 0);
    req[0] = 1'b0;
    finish_dma(2);

    // Single load with exact latencies.
    set_cmd(0, 1'b0, 3, 2, 1'b1);
    req = 4'b0001;
    exp_gnt_q.push_back(4'b0001); exp_done_q.push_back(4'b0001);
    step();
    check_eq("t1_start", 32'(dma_start), 1);
    check_eq("t1_dir", 32'(dma_dir), 0);
    check_eq("t1_x", 32'(dma_x), 3);
    check_eq("t1_y", 32'(dma_y), 2);
    check_eq("t1_buf", 32'(dma_buf), 1);
    check_eq("t1_busy", 32'(busy), 1);
    req = 4'b0000;
    repeat (9) step();
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    check_eq("t1_done_c11", 32'(done), 32'(4'b0001));
    check_eq("t1_busy_c11", 32'(busy), 1);
    step();
    check_eq("t1_idle_c12", 32'(busy), 0);

    // dma_done already high during ISSUE: done next cycle, no WAIT.
    set_cmd(1, 1'b1, 7, 9, 1'b0);
    req = 4'b0010;
    exp_gnt_q.push_back(4'b0010); exp_done_q.push_back(4'b0010);
    step();
    check_eq("t6_start", 32'(dma_start), 1);
    dma_done = 1'b1;
    req = 4'b0000;
    step();
    dma_done = 1'b0;
    check_eq("t6_done_fast", 32'(done), 32'(4'b0010));
    step();
    check_eq("t6_idle", 32'(busy), 0);
    // A request raised and withdrawn between edges is never granted.
    req[3] = 1'b1;
    @(negedge clk);
    req[3] = 1'b0;
    step();
    step();
    check_eq("t6_withdrawn_busy", 32'(busy), 0);
    check_eq("t6_withdrawn_gnt", 32'(gnt), 0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Four held loads rotate 0,1,2,3,0.
    req_dir = 4'b0000;
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, i + 10, i + 20, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_gnt_q.push_back(4'(1 << (k % 4)));
      exp_done_q.push_back(4'(1 << (k % 4)));
    end
    start_base = start_cnt;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t3_owner", 32'(owner), 32'(k % 4));
      check_eq("t3_x", 32'(dma_x), 32'((k % 4) + 10));
      req[k % 4] = 1'b0;
      step();
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      if (k < 4) req[k % 4] = 1'b1;
      else       req = 4'b0000;
      step();
    end
    step();
    check_eq("t3_start_count", 32'(start_cnt - start_base), 5);

    // Watchdog: no dma_done; release after 16 WAIT cycles.
    set_cmd(1, 1'b0, 4, 4, 1'b0);
    req = 4'b0010;
    exp_gnt_q.push_back(4'b0010); exp_done_q.push_back(4'b0010);
    step();
    req = 4'b0000;
    repeat (16) step();
    check_eq("t4_no_done_yet", 32'(done), 0);
    check_eq("t4_err_not_yet", 32'(err_timeout), 0);
    check_eq("t4_busy_wait", 32'(busy), 1);
    step();
    check_eq("t4_done_timeout", 32'(done), 32'(4'b0010));
    check_eq("t4_err_set", 32'(err_timeout), 1);
    step();
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    check_eq("t4_late_done_idle", 32'(busy), 0);
    check_eq("t4_err_sticky", 32'(err_timeout), 1);
    step();
    check_eq("t4_late_no_done", 32'(done), 0);

    // Async reset mid-WAIT.
    set_cmd(2, 1'b1, 33, 44, 1'b1);
    req = 4'b0100;
    exp_gnt_q.push_back(4'b0100);
    step();
    req = 4'b0000;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(busy), 0);
    check_eq("t5_rst_dir", 32'(dma_dir), 0);
    check_eq("t5_rst_x", 32'(dma_x), 0);
    check_eq("t5_rst_owner", 32'(owner), 0);
    check_eq("t5_rst_err", 32'(err_timeout), 0);
    step();
    rst_n = 1'b1;
    step();
    set_cmd(3, 1'b0, 1, 2, 1'b0);
    set_cmd(0, 1'b0, 6, 7, 1'b1);
    req = 4'b1001;
    exp_gnt_q.push_back(4'b0001); exp_done_q.push_back(4'b0001);
    step();
    check_eq("t5_owner_after_rst", 32'(owner), 0);
    check_eq("t5_x_after_rst", 32'(dma_x), 6);
    req = 4'b0000;
    finish_dma(2);
    step();

    check_eq("sb_gnt_empty", 32'(exp_gnt_q.size()), 0);
    check_eq("sb_done_empty", 32'(exp_done_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tile_dma_arbiter
